// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences each instruction and drives every datapath control.
// Optional bne support is enabled by defining MC_CTRL_BNE_EN.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       iord,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal_op
);
    // state    | meaning
    // FETCH    | read instr, PC+4     DECODE   | register read, branch target
    // MEMADR   | lw/sw address        MEMRD    | lw data read     MEMWB | lw writeback
    // MEMWR    | sw data write        EXECUTE  | R-type ALU op    ALUWB | R-type writeback
    // BRANCH   | beq/bne compare      ADDIEXEC | addi ALU op      ADDIWB | addi writeback
    // JUMP     | load jump target
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    state_t     state, next_state;
    logic       pcwrite, branch, taken;
    logic       memwrite_st, irwrite_st, regwrite_st, illegal_st;
    logic       funct_ok;
    logic [2:0] funct_alu;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= FETCH;
        else          state <= next_state;
    end

`ifdef MC_CTRL_BNE_EN
    logic bne_flag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            bne_flag <= 1'b0;
        else if (state == DECODE) bne_flag <= (op == OP_BNE);
    end

    assign taken = zero ^ bne_flag;
`else
    assign taken = zero;
`endif

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        next_state  = state;
        pcwrite     = 1'b0;
        branch      = 1'b0;
        memwrite_st = 1'b0;
        irwrite_st  = 1'b0;
        regwrite_st = 1'b0;
        illegal_st  = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        iord        = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        alucontrol  = ALU_ADD;
        case (state)
            FETCH: begin
                alusrcb    = 2'b01;
                irwrite_st = 1'b1;
                pcwrite    = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE: begin
                        if (funct_ok) next_state = EXECUTE;
                        else begin
                            next_state = FETCH;
                            illegal_st = 1'b1;
                        end
                    end
                    OP_BEQ:  next_state = BRANCH;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:  next_state = BRANCH;
`endif
                    OP_ADDI: next_state = ADDIEXEC;
                    OP_J:    next_state = JUMP;
                    default: begin
                        next_state = FETCH;
                        illegal_st = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord       = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                memtoreg    = 1'b1;
                regwrite_st = 1'b1;
                next_state  = FETCH;
            end
            MEMWR: begin
                iord        = 1'b1;
                memwrite_st = 1'b1;
                next_state  = FETCH;
            end
            EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
                next_state = ALUWB;
            end
            ALUWB: begin
                regdst      = 1'b1;
                regwrite_st = 1'b1;
                next_state  = FETCH;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                next_state = FETCH;
            end
            ADDIEXEC: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                regwrite_st = 1'b1;
                next_state  = FETCH;
            end
            JUMP: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

    // Write strobes are masked while reset is held so nothing leaks out mid-assertion.
    assign pcen       = reset_n & (pcwrite | (branch & taken));
    assign memwrite   = reset_n & memwrite_st;
    assign irwrite    = reset_n & irwrite_st;
    assign regwrite   = reset_n & regwrite_st;
    assign illegal_op = reset_n & illegal_st;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: per-instruction expected output sequences
// are built from the instruction class and compared against the DUT every cycle.
module tb_mips_multicycle_ctrl;

`ifdef MC_CTRL_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, BNE = 6'b000101;

    typedef struct packed {
        logic       pcwrite, branch, binv, memwrite, irwrite, regwrite;
        logic       regdst, memtoreg, iord, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] alu;
        logic       illegal;
    } exp_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        int         zm;
    } dir_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op, funct;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, regdst, memtoreg, iord, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op;

    int   checks = 0;
    int   errors = 0;
    int   zm     = 2;
    logic cmp_en = 1'b0;
    exp_t cur, ce;
    exp_t q[$];
    dir_t dq[$];
    logic        cep;
    logic [15:0] got, want;

    logic [5:0] op_tab[10]   = '{RT, RT, RT, LW, SW, BEQ, ADDI, JMP, BNE, 6'b111111};
    logic [5:0] funct_tab[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    mips_multicycle_ctrl dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .iord(iord), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    function automatic exp_t idle();
        exp_t e = '0;
        e.alu = 3'b010;
        return e;
    endfunction

    function automatic exp_t fetch_vec();
        exp_t e = idle();
        e.pcwrite = 1'b1;
        e.irwrite = 1'b1;
        e.alusrcb = 2'b01;
        return e;
    endfunction

    // Expected per-cycle outputs of one whole instruction, appended to q.
    task automatic build(input logic [5:0] o, input logic [5:0] f);
        exp_t e;
        logic legal, rok;
        logic [2:0] ralu;
        rok = 1'b1;
        case (f)
            6'b100000: ralu = 3'b010;
            6'b100010: ralu = 3'b110;
            6'b100100: ralu = 3'b000;
            6'b100101: ralu = 3'b001;
            6'b101010: ralu = 3'b111;
            default: begin ralu = 3'b010; rok = 1'b0; end
        endcase
        case (o)
            LW, SW, BEQ, ADDI, JMP: legal = 1'b1;
            RT:      legal = rok;
            BNE:     legal = BNE_EN;
            default: legal = 1'b0;
        endcase
        q.push_back(fetch_vec());
        e = idle(); e.alusrcb = 2'b11; e.illegal = !legal;
        q.push_back(e);
        if (legal) begin
            if (o == LW || o == SW) begin
                e = idle(); e.alusrca = 1'b1; e.alusrcb = 2'b10; q.push_back(e);
                if (o == LW) begin
                    e = idle(); e.iord = 1'b1; q.push_back(e);
                    e = idle(); e.memtoreg = 1'b1; e.regwrite = 1'b1; q.push_back(e);
                end else begin
                    e = idle(); e.iord = 1'b1; e.memwrite = 1'b1; q.push_back(e);
                end
            end else if (o == RT) begin
                e = idle(); e.alusrca = 1'b1; e.alu = ralu; q.push_back(e);
                e = idle(); e.regdst = 1'b1; e.regwrite = 1'b1; q.push_back(e);
            end else if (o == BEQ || o == BNE) begin
                e = idle(); e.alusrca = 1'b1; e.alu = 3'b110; e.pcsrc = 2'b01;
                e.branch = 1'b1; e.binv = (o == BNE); q.push_back(e);
            end else if (o == ADDI) begin
                e = idle(); e.alusrca = 1'b1; e.alusrcb = 2'b10; q.push_back(e);
                e = idle(); e.regwrite = 1'b1; q.push_back(e);
            end else begin
                e = idle(); e.pcsrc = 2'b10; e.pcwrite = 1'b1; q.push_back(e);
            end
        end
    endtask

    task automatic pin_len(input string name, input logic [5:0] o, input logic [5:0] f, input int n);
        q.delete();
        build(o, f);
        checks++;
        if (q.size() != n) begin
            errors++;
            $display("FAIL len_%s got %0d cycles want %0d", name, q.size(), n);
        end
        q.delete();
    endtask

    task automatic next_instr();
        dir_t d;
        if (dq.size() > 0) d = dq.pop_front();
        else begin
            d.op    = op_tab[$urandom_range(0, 9)];
            if (d.op == 6'b111111) d.op = 6'($urandom);
            d.funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : funct_tab[$urandom_range(0, 4)];
            d.zm    = 2;
        end
        op    = d.op;
        funct = d.funct;
        zm    = d.zm;
        build(d.op, d.funct);
        cur = q.pop_front();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (q.size() == 0) next_instr();
        else cur = q.pop_front();
        zero = (zm == 2) ? 1'($urandom) : zm[0];
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        cur = fetch_vec();
        q.delete();
        #1;
        checks++;
        if (memwrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_memwrite got %b want 0", memwrite);
        end
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;
        next_instr();
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            ce = cur;
            if (!reset_n) begin
                ce.pcwrite = 1'b0; ce.branch = 1'b0; ce.memwrite = 1'b0;
                ce.irwrite = 1'b0; ce.regwrite = 1'b0; ce.illegal = 1'b0;
            end
            cep  = ce.pcwrite | (ce.branch & (zero ^ ce.binv));
            want = {cep, ce.memwrite, ce.irwrite, ce.regwrite, ce.regdst, ce.memtoreg, ce.iord,
                    ce.alusrca, ce.alusrcb, ce.pcsrc, ce.alu, ce.illegal};
            got  = {pcen, memwrite, irwrite, regwrite, regdst, memtoreg, iord,
                    alusrca, alusrcb, pcsrc, alucontrol, illegal_op};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL outputs t=%0t op=%b funct=%b zero=%b got %b want %b",
                         $time, op, funct, zero, got, want);
            end
            if (!reset_n) begin
                checks++;
                if (pcen !== 1'b0 || irwrite !== 1'b0 || alucontrol !== 3'b010) begin
                    errors++;
                    $display("FAIL reset_state pcen=%b irwrite=%b alu=%b want 0 0 010",
                             pcen, irwrite, alucontrol);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        op      = 6'd0;
        funct   = 6'd0;
        zero    = 1'b0;
        cur     = fetch_vec();

        pin_len("lw", LW, 6'd0, 5);
        pin_len("sw", SW, 6'd0, 4);
        pin_len("rtype", RT, 6'b100000, 4);
        pin_len("addi", ADDI, 6'd0, 4);
        pin_len("beq", BEQ, 6'd0, 3);
        pin_len("j", JMP, 6'd0, 3);
        pin_len("illegal", RT, 6'b000000, 2);
        pin_len("bne", BNE, 6'd0, BNE_EN ? 3 : 2);
        build(RT, 6'b100010);
        checks++;
        if (q[2].alu !== 3'b110) begin
            errors++;
            $display("FAIL pin_sub_alu got %b want 110", q[2].alu);
        end
        q.delete();

        dq.push_back('{LW, 6'd0, 2});
        dq.push_back('{SW, 6'd0, 2});
        foreach (funct_tab[i]) dq.push_back('{RT, funct_tab[i], 2});
        dq.push_back('{RT, 6'b000000, 2});
        dq.push_back('{BEQ, 6'd0, 1});
        dq.push_back('{BEQ, 6'd0, 0});
        dq.push_back('{ADDI, 6'd0, 2});
        dq.push_back('{JMP, 6'd0, 2});
        dq.push_back('{BNE, 6'd0, 0});
        dq.push_back('{BNE, 6'd0, 1});
        dq.push_back('{6'b111111, 6'd0, 2});

        cmp_en = 1'b1;
        do_reset(3);
        while (dq.size() > 0) step();
        repeat (1200) step();
        while (q.size() > 0) step();

        dq.push_back('{SW, 6'd0, 2});
        step();
        step();
        step();
        @(posedge clk);
        #1;
        do_reset(2);
        repeat (60) step();
        while (q.size() > 0) step();
        @(negedge clk);
        #1;
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback and produces every datapath control, including the 3-bit ALU operation code fed to the datapath ALU.
- Consumes that ALU's zero flag for branch resolution.
- Sits between the instruction register (op/funct) and the shared-memory multicycle datapath.

Parameters:
- none

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- op  input  6  instr[31:26] from instruction register (stable outside FETCH)
- funct  input  6  instr[5:0]
- zero  input  1  ALU zero flag
- pcen  output  1  PC load enable = pcwrite | (branch & zero)
- memwrite  output  1  memory write strobe
- irwrite  output  1  instruction register load
- regwrite  output  1  register file write
- regdst  output  1  1: rd, 0: rt
- memtoreg  output  1  1: data register, 0: ALUOut
- iord  output  1  1: address = ALUOut, 0: PC
- alusrca  output  1  0: PC, 1: register A
- alusrcb  output  2  00 B, 01 const 4, 10 signimm, 11 signimm<<2
- pcsrc  output  2  00 ALU result, 01 ALUOut, 10 jump target
- alucontrol  output  3  ALU code: 010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal_op  output  1  one-cycle pulse on unsupported instruction

Behaviour:
- Moore FSM, one state register, async clear to FETCH on reset_n low.
- While reset_n low: pcen, memwrite, irwrite, regwrite and illegal_op forced 0 combinationally; the other outputs show FETCH values.
- Reset mid-instruction: abandon the instruction and restart at FETCH on the first clk after release; no partial writes after assertion.
- State outputs (unlisted write enables = 0, selects = 0):
  - FETCH: iord0, alusrca0, alusrcb01, add, pcsrc00, irwrite1, pcwrite1 -> DECODE.
  - DECODE: alusrca0, alusrcb11, add. Next by op: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEXEC; 000010 -> JUMP; other -> FETCH with illegal_op=1.
  - R-type with funct outside {100000,100010,100100,100101,101010}: also -> FETCH with illegal_op=1.
  - MEMADR: alusrca1, alusrcb10, add. lw -> MEMRD, sw -> MEMWR.
  - MEMRD: iord1 -> MEMWB.
  - MEMWB: regdst0, memtoreg1, regwrite1 -> FETCH.
  - MEMWR: iord1, memwrite1 -> FETCH.
  - EXECUTE: alusrca1, alusrcb00, alucontrol from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111 -> ALUWB.
  - ALUWB: regdst1, memtoreg0, regwrite1 -> FETCH.
  - BRANCH: alusrca1, alusrcb00, sub, pcsrc01, branch1 -> FETCH.
  - ADDIEXEC: alusrca1, alusrcb10, add -> ADDIWB.
  - ADDIWB: regdst0, memtoreg0, regwrite1 -> FETCH.
  - JUMP: pcsrc10, pcwrite1 -> FETCH.
- illegal_op is asserted only in the DECODE cycle; it is combinational from state/op/funct.
- Cycle counts per instruction:
  - lw: 5
  - sw, R-type, addi: 4
  - beq: 3
  - j: 3
  - illegal: 2
- alucontrol is 010 in every state not listed with a different code.
- pcen in BRANCH follows zero combinationally within the same cycle.

Optional Feature:
- Macro: MC_CTRL_BNE_EN.
- Defined: op 000101 (bne) in DECODE -> BRANCH. BRANCH latches a 1-bit bne flag in DECODE; pcen = pcwrite | (branch & (zero ^ bne_flag)). The flag clears to 0 on reset.
- Undefined: op 000101 is illegal (-> FETCH, illegal_op pulse). No flag register exists.

Test Plan:
- Reset: hold reset_n=0 for 3 clk -> pcen=memwrite=irwrite=regwrite=0, alucontrol=010. Release -> FETCH cycle with irwrite=1, pcen=1.
- lw (op 100011): states FETCH, DECODE, MEMADR, MEMRD, MEMWB. Require iord=1 in MEMRD; regwrite=1 and memtoreg=1 only in cycle 5; next cycle is FETCH.
- R-type sweep: op 000000 with funct 100000/100010/100100/100101/101010 -> EXECUTE alucontrol 010/110/000/001/111; ALUWB regwrite=1, regdst=1. funct 000000 -> illegal_op=1 for exactly one cycle, no regwrite.
- beq: zero=1 -> pcen=1, pcsrc=01, alucontrol=110 in cycle 3. zero=0 -> pcen=0 in cycle 3.
- Reset mid-operation: assert reset_n low during MEMWR -> memwrite drops to 0 immediately. After release, FETCH is the first state.
- With MC_CTRL_BNE_EN: op 000101, zero=0 -> pcen=1; zero=1 -> pcen=0. Without the macro: op 000101 -> illegal_op=1.
